// File: rtl/gate_deadtime_inserter.sv
// Dead-time insertion and shoot-through guard for three half-bridge legs.
// Optional macro SHOOT_THROUGH_FAULT_EN adds a sticky fault latch that blocks all legs.
module gate_deadtime_inserter #(
    parameter int DT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                in_H_A,
    input  logic                in_L_A,
    input  logic                in_H_B,
    input  logic                in_L_B,
    input  logic                in_H_C,
    input  logic                in_L_C,
    input  logic                fault_clear,
    output logic                gate_H_A,
    output logic                gate_L_A,
    output logic                gate_H_B,
    output logic                gate_L_B,
    output logic                gate_H_C,
    output logic                gate_L_C,
    output logic                fault,
    output logic [5:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t              state_q [3];
    state_t              state_d [3];
    logic [DT_WIDTH-1:0] cnt_q   [3];
    logic [DT_WIDTH-1:0] cnt_d   [3];

    logic [2:0]          in_h;
    logic [2:0]          in_l;
    logic [2:0]          req_h;
    logic [2:0]          req_l;
    logic [2:0]          illegal;
    logic [2:0]          gate_h_q;
    logic [2:0]          gate_l_q;
    logic [DT_WIDTH-1:0] d_minus1;
    logic                block;
    logic                blk_q;
    logic                fault_q;

    // Index 0 = phase A, 1 = phase B, 2 = phase C.
    assign in_h    = {in_H_C, in_H_B, in_H_A};
    assign in_l    = {in_L_C, in_L_B, in_L_A};
    assign req_h   = in_h & ~in_l;
    assign req_l   = in_l & ~in_h;
    assign illegal = in_h & in_l;

    // D = max(dead_time, 1); the counter holds D-1 so the interval is D cycles.
    assign d_minus1 = (dead_time == '0) ? '0 : dead_time - DT_WIDTH'(1);

`ifdef SHOOT_THROUGH_FAULT_EN
    logic fault_d;

    // A same-cycle ILLEGAL wins over fault_clear.
    always_comb begin
        fault_d = fault_q;
        if (|illegal) begin
            fault_d = 1'b1;
        end else if (fault_clear) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign block = ~enable | fault_q | (|illegal);
`else
    logic fault_clear_unused;

    assign fault_clear_unused = fault_clear;
    assign fault_q            = 1'b0;
    assign block              = ~enable;
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (block) begin
                state_d[i] = DEAD;
                cnt_d[i]   = d_minus1;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (req_h[i]) begin
                            state_d[i] = HIGH;
                        end else if (req_l[i]) begin
                            state_d[i] = LOW;
                        end
                    end
                    HIGH: begin
                        if (!req_h[i]) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = d_minus1;
                        end
                    end
                    LOW: begin
                        if (!req_l[i]) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = d_minus1;
                        end
                    end
                    DEAD: begin
                        // The first unblocked edge reloads again so a full D follows release.
                        if (blk_q) begin
                            cnt_d[i] = d_minus1;
                        end else if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end else if (req_h[i]) begin
                            state_d[i] = HIGH;
                        end else if (req_l[i]) begin
                            state_d[i] = LOW;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = DEAD;
                        cnt_d[i]   = d_minus1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q    <= 1'b0;
            gate_h_q <= '0;
            gate_l_q <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            blk_q <= block;
            for (int i = 0; i < 3; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                gate_h_q[i] <= (state_d[i] == HIGH);
                gate_l_q[i] <= (state_d[i] == LOW);
            end
        end
    end

    assign gate_H_A  = gate_h_q[0];
    assign gate_L_A  = gate_l_q[0];
    assign gate_H_B  = gate_h_q[1];
    assign gate_L_B  = gate_l_q[1];
    assign gate_H_C  = gate_h_q[2];
    assign gate_L_C  = gate_l_q[2];
    assign fault     = fault_q;
    assign state_dbg = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_gate_deadtime_inserter.sv
// Scoreboard bench for gate_deadtime_inserter: expected {fault, gates} per cycle
// are queued when stimulus is driven and compared one cycle later.
module tb_gate_deadtime_inserter;

    localparam int DT_WIDTH = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [DT_WIDTH-1:0] dead_time;
    logic                in_H_A, in_L_A, in_H_B, in_L_B, in_H_C, in_L_C;
    logic                fault_clear;
    logic                gate_H_A, gate_L_A, gate_H_B, gate_L_B, gate_H_C, gate_L_C;
    logic                fault;
    logic [5:0]          state_dbg;

    logic [6:0]          exp_q[$];
    int                  n_vec = 0;
    int                  n_err = 0;
    logic                en = 1'b0;

    gate_deadtime_inserter #(.DT_WIDTH(DT_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .dead_time   (dead_time),
        .in_H_A      (in_H_A),
        .in_L_A      (in_L_A),
        .in_H_B      (in_H_B),
        .in_L_B      (in_L_B),
        .in_H_C      (in_H_C),
        .in_L_C      (in_L_C),
        .fault_clear (fault_clear),
        .gate_H_A    (gate_H_A),
        .gate_L_A    (gate_L_A),
        .gate_H_B    (gate_H_B),
        .gate_L_B    (gate_L_B),
        .gate_H_C    (gate_H_C),
        .gate_L_C    (gate_L_C),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] observed();
        return {fault, gate_H_A, gate_L_A, gate_H_B, gate_L_B, gate_H_C, gate_L_C};
    endfunction

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input logic [5:0] req);
        {in_H_A, in_L_A, in_H_B, in_L_B, in_H_C, in_L_C} = req;
    endtask

    // Drive one cycle of requests, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic [5:0] req, input logic [6:0] exp);
        set_req(req);
        enable = en;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_vec(tag, observed(), exp_q.pop_front());
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        dead_time   = 16'd50;
        fault_clear = 1'b0;
        set_req(6'b000000);
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_out", observed(), 7'b0);
        check_vec("reset_state", {1'b0, state_dbg}, 7'b0);
        reset = 1'b0;

        // Turn-on from IDLE with 1-cycle latency
        en = 1'b1;
        cyc("turn_on_HA", 6'b100000, 7'b0_100000);
        repeat (3) cyc("hold_HA", 6'b100000, 7'b0_100000);

        // H->L with D=50: 50 cycles both-off
        for (int i = 0; i < 50; i++) cyc("dead50_HL", 6'b010000, 7'b0);
        cyc("after_dead50_L", 6'b010000, 7'b0_010000);

        // dead_time = 0 -> one cycle both-off
        dead_time = 16'd0;
        cyc("dead0_LH", 6'b100000, 7'b0);
        cyc("after_dead0_H", 6'b100000, 7'b0_100000);

        // H->NONE->H inside the interval, mid-interval dead_time change ignored
        dead_time = 16'd50;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) dead_time = 16'd3;
            if (i == 30) dead_time = 16'd50;
            cyc("return_H_dead", (i < 5) ? 6'b000000 : 6'b100000, 7'b0);
        end
        cyc("return_H_on", 6'b100000, 7'b0_100000);

        // B and C turn on, then all three switch simultaneously
        cyc("bc_on", 6'b101010, 7'b0_101010);
        for (int i = 0; i < 50; i++) cyc("all_switch_dead", 6'b010101, 7'b0);
        cyc("all_switch_on", 6'b010101, 7'b0_010101);

        // Enable low for one cycle: 51 cycles off, then resume
        en = 1'b0;
        cyc("enable_low", 6'b010101, 7'b0);
        en = 1'b1;
        for (int i = 0; i < 50; i++) cyc("enable_release_dead", 6'b010101, 7'b0);
        cyc("enable_resume", 6'b010101, 7'b0_010101);

`ifdef SHOOT_THROUGH_FAULT_EN
        // ILLEGAL on B: sticky fault, clear blocked while ILLEGAL, clean clear resumes
        cyc("fault_set", 6'b011101, 7'b1_000000);
        fault_clear = 1'b1;
        cyc("fault_clear_blocked", 6'b011101, 7'b1_000000);
        cyc("fault_clear_clean", 6'b010101, 7'b0_000000);
        fault_clear = 1'b0;
        for (int i = 0; i < 50; i++) cyc("fault_release_dead", 6'b010101, 7'b0);
        cyc("fault_resume", 6'b010101, 7'b0_010101);
`else
        // Without the latch ILLEGAL just sends B to DEAD, fault_clear ignored
        cyc("illegal_B", 6'b011101, 7'b0_010001);
        fault_clear = 1'b1;
        for (int i = 0; i < 49; i++) cyc("illegal_B_dead", 6'b010101, 7'b0_010001);
        fault_clear = 1'b0;
        cyc("illegal_B_resume", 6'b010101, 7'b0_010101);
`endif

        // Async reset mid-DEAD (A) and mid-conduction (B, C)
        repeat (3) cyc("pre_reset_A_dead", 6'b100101, 7'b0_000101);
`ifdef SHOOT_THROUGH_FAULT_EN
        cyc("pre_reset_fault", 6'b110101, 7'b1_000000);
`endif
        #2;
        reset = 1'b1;
        #1;
        check_vec("async_reset_out", observed(), 7'b0);
        check_vec("async_reset_state", {1'b0, state_dbg}, 7'b0);
        set_req(6'b000000);
        #2;
        reset = 1'b0;
        cyc("post_reset_idle", 6'b000000, 7'b0);
        cyc("post_reset_turn_on", 6'b100000, 7'b0_100000);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
